// File: rtl/painterengine_gpu_blend_pkg.sv
// Shared constants for the PainterEngine GPU blend pipeline: blend modes, pixel layouts
// and the pipeline depth.
package painterengine_gpu_blend_pkg;

  localparam logic [1:0] BLEND_OVER = 2'd0;
  localparam logic [1:0] BLEND_ADD  = 2'd1;
  localparam logic [1:0] BLEND_MUL  = 2'd2;
  localparam logic [1:0] BLEND_PASS = 2'd3;

  localparam logic ARGB_MODE_AXXX = 1'b1;
  localparam logic ARGB_MODE_XXXA = 1'b0;

  localparam int unsigned BLEND_LATENCY = 4;

endpackage

// File: rtl/painterengine_gpu_blend_lane.sv
// One pixel of the blend datapath: unpack (S0), weight (S1), products (S2) and
// finish/repack (S3), all advancing on a shared enable.
module painterengine_gpu_blend_lane
  import painterengine_gpu_blend_pkg::*;
#(
  parameter int unsigned CH_W = 8
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              en_i,
  input  logic              argb_mode_i,
  input  logic [1:0]        blend_mode_i,
  input  logic [4*CH_W-1:0] data1_i,
  input  logic [4*CH_W-1:0] data2_i,
  input  logic [4*CH_W-1:0] blend_i,
  output logic [4*CH_W-1:0] data_o
);

  localparam int unsigned PW = 4 * CH_W;
  localparam int unsigned EW = 2 * CH_W + 2;
  localparam logic [CH_W-1:0] MaxC = '1;
  localparam logic [EW-1:0] MaxE  = EW'(MaxC);
  localparam logic [EW-1:0] OneE  = EW'(1);
  localparam logic [EW-1:0] FullE = MaxE + OneE;

  // Channel index 0 = a, 1 = r, 2 = g, 3 = b.
  typedef logic [3:0][CH_W-1:0] argb_t;

  function automatic argb_t unpack(input logic [PW-1:0] p, input logic mode);
    argb_t v;
    v = '0;
    for (int i = 0; i < 4; i++) begin
      v[i] = (mode == ARGB_MODE_AXXX) ? p[(3-i)*CH_W +: CH_W] : p[i*CH_W +: CH_W];
    end
    return v;
  endfunction

  function automatic logic [PW-1:0] pack(input argb_t v, input logic mode);
    logic [PW-1:0] p;
    p = '0;
    for (int i = 0; i < 4; i++) begin
      if (mode == ARGB_MODE_XXXA) p[i*CH_W +: CH_W] = v[i];
      else                        p[(3-i)*CH_W +: CH_W] = v[i];
    end
    return p;
  endfunction

  argb_t               s0_d1_q, s0_d2_q, s0_bl_q;
  logic                s0_am_q, s1_am_q, s2_am_q;
  logic [1:0]          s0_bm_q, s1_bm_q, s2_bm_q;
  argb_t               s1_w_q, s1_w_d, s1_d2_q;
  logic [3:0][EW-1:0]  s2_t_q, s2_t_d;
  logic [PW-1:0]       s3_q, s3_d;

  // S1: saturating weights of source 1 by the blend colour (Q1.(CH_W-1) scale).
  always_comb begin
    logic [EW-1:0] prod;
    prod   = '0;
    s1_w_d = '0;
    for (int i = 0; i < 4; i++) begin
      prod      = (EW'(s0_d1_q[i]) * EW'(s0_bl_q[i])) >> (CH_W - 1);
      s1_w_d[i] = (prod > MaxE) ? MaxC : CH_W'(prod);
    end
  end

  // S2: mode-specific complement/product terms, finished by S3.
  always_comb begin
    logic [EW-1:0] wa, a2, wc, c2;
    wa     = EW'(s1_w_q[0]);
    a2     = EW'(s1_d2_q[0]);
    wc     = '0;
    c2     = '0;
    s2_t_d = '0;
    case (s1_bm_q)
      BLEND_OVER: s2_t_d[0] = (FullE - a2) * (MaxE - wa);
      BLEND_ADD:  s2_t_d[0] = (a2 > wa) ? a2 : wa;
      default:    s2_t_d[0] = a2;
    endcase
    for (int i = 1; i < 4; i++) begin
      wc = EW'(s1_w_q[i]);
      c2 = EW'(s1_d2_q[i]);
      case (s1_bm_q)
        BLEND_OVER: s2_t_d[i] = (FullE - wa) * c2 + (wa + OneE) * wc;
        BLEND_ADD:  s2_t_d[i] = c2 + wc;
        BLEND_MUL:  s2_t_d[i] = c2 * (wc + OneE);
        default:    s2_t_d[i] = c2;
      endcase
    end
  end

  always_comb begin
    argb_t r;
    r = '0;
    case (s2_bm_q)
      BLEND_OVER: r[0] = MaxC - CH_W'(s2_t_q[0] >> CH_W);
      default:    r[0] = CH_W'(s2_t_q[0]);
    endcase
    for (int i = 1; i < 4; i++) begin
      case (s2_bm_q)
        BLEND_ADD:  r[i] = (s2_t_q[i] > MaxE) ? MaxC : CH_W'(s2_t_q[i]);
        BLEND_PASS: r[i] = CH_W'(s2_t_q[i]);
        default:    r[i] = CH_W'(s2_t_q[i] >> CH_W);
      endcase
    end
    s3_d = pack(r, s2_am_q);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s0_d1_q <= '0;
      s0_d2_q <= '0;
      s0_bl_q <= '0;
      s0_am_q <= 1'b0;
      s0_bm_q <= '0;
      s1_w_q  <= '0;
      s1_d2_q <= '0;
      s1_am_q <= 1'b0;
      s1_bm_q <= '0;
      s2_t_q  <= '0;
      s2_am_q <= 1'b0;
      s2_bm_q <= '0;
      s3_q    <= '0;
    end else if (en_i) begin
      s0_d1_q <= unpack(data1_i, argb_mode_i);
      s0_d2_q <= unpack(data2_i, argb_mode_i);
      s0_bl_q <= unpack(blend_i, ARGB_MODE_AXXX);
      s0_am_q <= argb_mode_i;
      s0_bm_q <= blend_mode_i;
      s1_w_q  <= s1_w_d;
      s1_d2_q <= s0_d2_q;
      s1_am_q <= s0_am_q;
      s1_bm_q <= s0_bm_q;
      s2_t_q  <= s2_t_d;
      s2_am_q <= s1_am_q;
      s2_bm_q <= s1_bm_q;
      s3_q    <= s3_d;
    end
  end

  assign data_o = s3_q;

endmodule

// File: rtl/painterengine_gpu_blend_pipe.sv
// Back-pressured multi-lane ARGB blend pipeline: valid chain, handshake and output pixel
// counter around LANES copies of the per-pixel datapath.
module painterengine_gpu_blend_pipe
  import painterengine_gpu_blend_pkg::*;
#(
  parameter int unsigned CH_W  = 8,
  parameter int unsigned LANES = 1
) (
  input  logic                      i_wire_clock,
  input  logic                      i_wire_resetn,
  input  logic                      i_wire_in_valid,
  output logic                      o_wire_in_ready,
  input  logic                      i_wire_argb_mode,
  input  logic [1:0]                i_wire_blend_mode,
  input  logic [LANES*4*CH_W-1:0]   i_wire_data1_in,
  input  logic [LANES*4*CH_W-1:0]   i_wire_data2_in,
  input  logic [4*CH_W-1:0]         i_wire_blend,
  output logic [LANES*4*CH_W-1:0]   o_wire_data_out,
  output logic                      o_wire_out_valid,
  input  logic                      i_wire_out_ready,
  input  logic                      i_wire_count_clear,
  output logic [31:0]               o_wire_pix_count
);

  localparam int unsigned PW = 4 * CH_W;

  logic [BLEND_LATENCY-1:0] valid_q, valid_d;
  logic [31:0]              count_q, count_d;
  logic [LANES*PW-1:0]      lane_data;
  logic                     adv;

  // The whole pipe moves as one; bubbles are not squeezed out under stall.
  assign adv             = !valid_q[BLEND_LATENCY-1] || i_wire_out_ready;
  assign o_wire_in_ready = adv;

  always_comb begin
    valid_d = valid_q;
    if (adv) valid_d = {valid_q[BLEND_LATENCY-2:0], i_wire_in_valid};
    count_d = count_q;
    if (i_wire_count_clear) begin
      count_d = '0;
    end else if (o_wire_out_valid && i_wire_out_ready) begin
      count_d = count_q + 32'(LANES);
    end
  end

  always_ff @(posedge i_wire_clock or negedge i_wire_resetn) begin
    if (!i_wire_resetn) begin
      valid_q <= '0;
      count_q <= '0;
    end else begin
      valid_q <= valid_d;
      count_q <= count_d;
    end
  end

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    painterengine_gpu_blend_lane #(
      .CH_W(CH_W)
    ) u_lane (
      .clk_i       (i_wire_clock),
      .rst_ni      (i_wire_resetn),
      .en_i        (adv),
      .argb_mode_i (i_wire_argb_mode),
      .blend_mode_i(i_wire_blend_mode),
      .data1_i     (i_wire_data1_in[l*PW +: PW]),
      .data2_i     (i_wire_data2_in[l*PW +: PW]),
      .blend_i     (i_wire_blend),
      .data_o      (lane_data[l*PW +: PW])
    );
  end

  assign o_wire_out_valid = valid_q[BLEND_LATENCY-1];
  assign o_wire_data_out  = o_wire_out_valid ? lane_data : '0;
  assign o_wire_pix_count = count_q;

endmodule

// File: doc/painterengine_gpu_blend_pipe.md
Name: painterengine_gpu_blend_pipe

Overview:
- Parametrised, back-pressured successor to the GPU two-source alpha blender.
- Takes LANES pixels per beat from source 1 (foreground) and source 2 (background), plus one per-beat ARGB blend colour.
- Blends them with a per-beat mode: OVER, ADD or MUL.
- Sits between the two source-read FIFOs and the framebuffer writer. It uses a valid/ready handshake, so it never drops data under downstream stall.

Parameters:
- CH_W, 8: bits per channel. MAX = 2^CH_W-1; M = 2^CH_W.
- LANES, 1: pixels per beat.
- PW, 4*CH_W: pixel width (derived; not overridable).

Ports:
- i_wire_clock  in  1  clock
- i_wire_resetn  in  1  asynchronous active-low reset
- i_wire_in_valid  in  1  beat offered
- o_wire_in_ready  out  1  beat accepted when high with valid
- i_wire_argb_mode  in  1  1 = AXXX (A in MSB byte), 0 = XXXA (A in bits [CH_W-1:0], then R, G, B upward); sampled with the beat
- i_wire_blend_mode  in  2  0 = OVER, 1 = ADD, 2 = MUL, 3 = pass source 2; sampled with the beat
- i_wire_data1_in  in  LANES*PW  source 1 pixels; lane 0 in LSBs
- i_wire_data2_in  in  LANES*PW  source 2 pixels
- i_wire_blend  in  PW  blend colour, always AXXX layout
- o_wire_data_out  out  LANES*PW  result, packed in the layout of its own beat's argb_mode
- o_wire_out_valid  out  1  result valid
- i_wire_out_ready  in  1  downstream accepts
- i_wire_count_clear  in  1  synchronous clear of o_wire_pix_count
- o_wire_pix_count  out  32  pixels output since the last clear, wrapping

Behaviour:
- Reset is asynchronous, active-low; the clock is i_wire_clock. During reset:
  - all pipeline valids = 0, o_wire_out_valid = 0
  - o_wire_data_out = 0, o_wire_pix_count = 0
- Pipeline: 4 registered stages, S0 to S3. S3 drives the outputs.
- Stall control: adv = !S3.valid || i_wire_out_ready. o_wire_in_ready = adv (combinational).
  - When adv = 1, all stages shift together. When adv = 0, all stages hold.
  - Latency is exactly 4 cycles from the input handshake to o_wire_out_valid, given i_wire_out_ready held high.
  - Throughput is 1 beat/cycle.
- Bubbles shift as valid = 0. Data registers of invalid stages may hold stale values; o_wire_data_out must be 0 whenever o_wire_out_valid = 0.
- argb_mode and blend_mode travel with their beat. Changing them between consecutive beats affects only the later beat.
- S0: unpack each lane by argb_mode into (a, r, g, b); register the mode bits.
- S1, per lane, with c in {r, g, b} and the matching blend channel bc:
  - wa = min((a1*ba) >> (CH_W-1), MAX)
  - wc = min((c1*bc) >> (CH_W-1), MAX)
  - These saturate (the previous generation truncated).
- S2: form the complements and products (multipliers registered).
- S3, per mode:
  - OVER: c = ((M-wa)*c2 + (wa+1)*wc) >> CH_W; a = MAX - (((M-a2)*(MAX-wa)) >> CH_W)
  - ADD: c = min(c2 + wc, MAX); a = max(a2, wa)
  - MUL: c = (c2*(wc+1)) >> CH_W; a = a2
  - mode 3: output = source 2 unchanged
  - Then repack by the beat's argb_mode.
- Intermediate products use 2*CH_W+2 bits. No intermediate may overflow for any input.
- o_wire_pix_count adds LANES on each output handshake (out_valid && out_ready).
  - i_wire_count_clear takes priority over a simultaneous increment; the result is 0.
  - Wraps modulo 2^32.
- Back-pressure while full: all 4 stages valid with out_ready = 0. In that state in_ready = 0 and the outputs hold stable.
- If out_ready rises in the same cycle as in_valid, the beat is accepted and the pipeline advances.
- Reset mid-stream: all in-flight beats are discarded and the count is zeroed.

Decomposition:
- Package painterengine_gpu_blend_pkg holds:
  - mode constants BLEND_OVER=0, BLEND_ADD=1, BLEND_MUL=2, BLEND_PASS=3
  - ARGB_MODE_AXXX=1, ARGB_MODE_XXXA=0
  - the stage count constant BLEND_LATENCY=4
- One sub-module, painterengine_gpu_blend_lane: the per-pixel S0–S3 datapath with a shared enable. It is instantiated LANES times.
- The top level holds the valid chain, the handshake and the counter.

Test Plan:
All cases use CH_W=8 and LANES=1 unless stated.
- OVER, AXXX: d1=0xFF800000, blend=0xFFFFFFFF, d2=0x40100000 -> 4 cycles later out=0xFFFF0000, with valid pulsing 1 cycle.
- OVER with a1=0: d1=0x00FFFFFF, blend=0xFFFFFFFF, d2=0x40102030 -> out=0x40102030 (source 2 preserved, a=64).
- ADD saturation: d1=0x00400000, blend=0x00800000, d2=0x00F00000 -> red=0xFF (0xF0+0x40 saturated).
- XXXA layout: a d1/d2 beat equivalent to case 1 with bytes swizzled to XXXA -> output in XXXA layout equals the swizzled 0xFFFF0000. Beats mixing modes back-to-back each pack independently.
- Back-pressure: stream 10 beats with out_ready toggling 1,0,0,1,... -> all 10 outputs arrive in order with no loss or duplication, in_ready = 0 while 4 beats are held, and pix_count = 10.
- Clear/reset: count_clear coincident with an output handshake -> count = 0. Async reset with 3 beats in flight -> out_valid = 0 immediately and no stale output after release.
